// File: rtl/tcb_cmn_cmd_man.sv
// TCB manager for the common RW channel: command stream in, TCB transfers out,
// responses captured after the fixed delay DLY and returned in order through a FIFO.
module tcb_cmn_cmd_man #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned DLY       = 1,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_vld,
  output logic            cmd_rdy,
  input  logic            cmd_wen,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW/8-1:0] cmd_ben,
  input  logic [DW-1:0]   cmd_wdt,
  output logic            tcb_vld,
  input  logic            tcb_rdy,
  output logic            tcb_wen,
  output logic [AW-1:0]   tcb_adr,
  output logic [DW/8-1:0] tcb_ben,
  output logic [DW-1:0]   tcb_wdt,
  input  logic [DW-1:0]   tcb_rdt,
  input  logic            tcb_sts,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic            rsp_wen,
  output logic [DW-1:0]   rsp_rdt,
  output logic            rsp_sts
);

  localparam int unsigned BW = DW/8;
  localparam int unsigned PW = $clog2(RSP_DEPTH);
  localparam int unsigned CW = $clog2(RSP_DEPTH+1);
  localparam int unsigned EW = DW+2;

  logic          req_full;
  logic          req_wen;
  logic [AW-1:0] req_adr;
  logic [BW-1:0] req_ben;
  logic [DW-1:0] req_wdt;
  logic [CW-1:0] cnt;
  logic          trn;
  logic          accept;
  logic          pop;
  logic          push;
  logic          tap;
  logic          tap_wen;

  assign trn = req_full & tcb_rdy;
  assign pop = rsp_vld & rsp_rdy;

  // A full credit count still admits a command in the cycle a response leaves.
  assign cmd_rdy = rst_n & (~req_full | tcb_rdy) & ((cnt != CW'(RSP_DEPTH)) | pop);
  assign accept  = cmd_vld & cmd_rdy;

  assign tcb_vld = req_full;
  assign tcb_wen = req_wen;
  assign tcb_adr = req_adr;
  assign tcb_ben = req_ben;
  assign tcb_wdt = req_wdt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_full <= 1'b0;
      req_wen  <= 1'b0;
      req_adr  <= '0;
      req_ben  <= '0;
      req_wdt  <= '0;
    end else if (accept) begin
      req_full <= 1'b1;
      req_wen  <= cmd_wen;
      req_adr  <= cmd_adr;
      req_ben  <= cmd_ben;
      req_wdt  <= cmd_wdt;
    end else if (trn) begin
      req_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  generate
    if (DLY == 0) begin : g_nodly
      assign tap     = trn;
      assign tap_wen = req_wen;
    end else begin : g_dly
      logic [DLY-1:0] pipe_trn;
      logic [DLY-1:0] pipe_wen;
      genvar gi;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_trn[0] <= 1'b0;
          pipe_wen[0] <= 1'b0;
        end else begin
          pipe_trn[0] <= trn;
          pipe_wen[0] <= req_wen;
        end
      end

      for (gi = 1; gi < DLY; gi++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            pipe_trn[gi] <= 1'b0;
            pipe_wen[gi] <= 1'b0;
          end else begin
            pipe_trn[gi] <= pipe_trn[gi-1];
            pipe_wen[gi] <= pipe_wen[gi-1];
          end
        end
      end

      assign tap     = pipe_trn[DLY-1];
      assign tap_wen = pipe_wen[DLY-1];
    end
  endgenerate

  logic [EW-1:0] rsp_mem [RSP_DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          fifo_full;
  logic [EW-1:0] head;

  assign push      = tap;
  assign rsp_vld   = (wr_ptr != rd_ptr);
  assign fifo_full = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  // Write responses carry no data, so their read-data field is forced to zero.
  always_ff @(posedge clk) begin
    if (push) rsp_mem[wr_ptr[PW-1:0]] <= {tap_wen, (tap_wen ? {DW{1'b0}} : tcb_rdt), tcb_sts};
  end

  assign head    = rsp_mem[rd_ptr[PW-1:0]];
  assign rsp_wen = rsp_vld & head[EW-1];
  assign rsp_rdt = rsp_vld ? head[DW:1] : '0;
  assign rsp_sts = rsp_vld & head[0];

  // Credits bound outstanding commands, so a push can never meet a full FIFO.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));

endmodule

// File: tb/tb_tcb_cmn_cmd_man.sv
// Directed bench for tcb_cmn_cmd_man with a DLY=1 subordinate model and response monitor.
module tb_tcb_cmn_cmd_man;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned DLY = 1;
  localparam int unsigned RSP_DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_vld;
  logic          cmd_rdy;
  logic          cmd_wen;
  logic [AW-1:0] cmd_adr;
  logic [3:0]    cmd_ben;
  logic [DW-1:0] cmd_wdt;
  logic          tcb_vld;
  logic          tcb_rdy;
  logic          tcb_wen;
  logic [AW-1:0] tcb_adr;
  logic [3:0]    tcb_ben;
  logic [DW-1:0] tcb_wdt;
  logic [DW-1:0] tcb_rdt;
  logic          tcb_sts;
  logic          rsp_vld;
  logic          rsp_rdy;
  logic          rsp_wen;
  logic [DW-1:0] rsp_rdt;
  logic          rsp_sts;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] err_adr = 32'hFFFF_FFFF;
  logic [33:0] rsp_q[$];
  int          trn_q[$];

  tcb_cmn_cmd_man #(.AW(AW), .DW(DW), .DLY(DLY), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_wen(cmd_wen), .cmd_adr(cmd_adr),
    .cmd_ben(cmd_ben), .cmd_wdt(cmd_wdt),
    .tcb_vld(tcb_vld), .tcb_rdy(tcb_rdy), .tcb_wen(tcb_wen), .tcb_adr(tcb_adr),
    .tcb_ben(tcb_ben), .tcb_wdt(tcb_wdt), .tcb_rdt(tcb_rdt), .tcb_sts(tcb_sts),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_wen(rsp_wen), .rsp_rdt(rsp_rdt),
    .rsp_sts(rsp_sts)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return (a == 32'h8) ? 32'h1234_5678 : {16'hC0DE, a[15:0]};
  endfunction

  // Subordinate answers one cycle after each transfer; junk otherwise.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tcb_vld && tcb_rdy) begin
      tcb_rdt <= tcb_wen ? 32'hBAD0_0000 : rd_val(tcb_adr);
      tcb_sts <= (tcb_adr == err_adr);
    end else begin
      tcb_rdt <= 32'hDEAD_BEEF;
      tcb_sts <= 1'b0;
    end
    if (rst_n && rsp_vld && rsp_rdy) rsp_q.push_back({rsp_wen, rsp_rdt, rsp_sts});
    if (rst_n && tcb_vld && tcb_rdy) trn_q.push_back(cyc);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_vld = 1'b0; cmd_wen = 1'b0; cmd_adr = '0; cmd_ben = '0; cmd_wdt = '0;
    tcb_rdy = 1'b0; rsp_rdy = 1'b0;
    #2;
    checks++;
    if ({tcb_vld, cmd_rdy, rsp_vld} !== 3'b000) begin
      errors++; $display("FAIL reset_ctl: got %b expected 000", {tcb_vld, cmd_rdy, rsp_vld});
    end
    checks++;
    if ({tcb_wen, tcb_adr, tcb_ben, tcb_wdt} !== '0) begin
      errors++; $display("FAIL reset_tcb: got %h expected 0", {tcb_wen, tcb_adr, tcb_ben, tcb_wdt});
    end
    checks++;
    if ({rsp_wen, rsp_rdt, rsp_sts} !== '0) begin
      errors++; $display("FAIL reset_rsp: got %h expected 0", {rsp_wen, rsp_rdt, rsp_sts});
    end
    step(); step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL reset_release_rdy: got %b expected 1", cmd_rdy);
    end
    $display("test_reset done");
  endtask

  task automatic test_single(input logic wen, input logic [31:0] adr, input logic [31:0] wdt,
                             input logic [31:0] exp_rdt);
    rsp_q.delete(); trn_q.delete();
    tcb_rdy = 1'b1; rsp_rdy = 1'b1;
    cmd_vld = 1'b1; cmd_wen = wen; cmd_adr = adr; cmd_ben = 4'hF; cmd_wdt = wdt;
    #1;
    checks++;
    if (cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL single_cmd_rdy: got %b expected 1", cmd_rdy);
    end
    step();
    cmd_vld = 1'b0;
    #1;
    checks++;
    if ({tcb_vld, tcb_wen, tcb_adr, tcb_ben, tcb_wdt} !== {1'b1, wen, adr, 4'hF, wdt}) begin
      errors++; $display("FAIL single_tcb_req: got %h expected %h",
                         {tcb_vld, tcb_wen, tcb_adr, tcb_ben, tcb_wdt}, {1'b1, wen, adr, 4'hF, wdt});
    end
    step();
    #1;
    checks++;
    if ({tcb_vld, rsp_vld} !== 2'b00) begin
      errors++; $display("FAIL single_after_trn: got %b expected 00", {tcb_vld, rsp_vld});
    end
    step();
    #1;
    checks++;
    if ({rsp_vld, rsp_wen, rsp_rdt, rsp_sts} !== {1'b1, wen, exp_rdt, 1'b0}) begin
      errors++; $display("FAIL single_rsp: got %h expected %h",
                         {rsp_vld, rsp_wen, rsp_rdt, rsp_sts}, {1'b1, wen, exp_rdt, 1'b0});
    end
    step();
    #1;
    checks++;
    if (rsp_vld !== 1'b0 || rsp_q.size() != 1) begin
      errors++; $display("FAIL single_pop: got vld=%b n=%0d expected vld=0 n=1", rsp_vld, rsp_q.size());
    end
    $display("test_single wen=%b adr=%h done", wen, adr);
  endtask

  task automatic test_wait_states();
    rsp_q.delete(); trn_q.delete();
    tcb_rdy = 1'b0; rsp_rdy = 1'b1;
    cmd_vld = 1'b1; cmd_wen = 1'b1; cmd_adr = 32'h20; cmd_ben = 4'h3; cmd_wdt = 32'h11;
    #1;
    step();
    cmd_wen = 1'b0; cmd_adr = 32'h24; cmd_ben = 4'hF; cmd_wdt = 32'h0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({tcb_vld, tcb_adr, tcb_wdt} !== {1'b1, 32'h20, 32'h11}) begin
        errors++; $display("FAIL ws_hold[%0d]: got %h expected %h", k,
                           {tcb_vld, tcb_adr, tcb_wdt}, {1'b1, 32'h20, 32'h11});
      end
      checks++;
      if (cmd_rdy !== 1'b0) begin
        errors++; $display("FAIL ws_cmd_rdy[%0d]: got %b expected 0", k, cmd_rdy);
      end
      step();
    end
    tcb_rdy = 1'b1;
    #1;
    checks++;
    if (cmd_rdy !== 1'b1) begin
      errors++; $display("FAIL ws_same_cycle_rdy: got %b expected 1", cmd_rdy);
    end
    step();
    cmd_vld = 1'b0;
    #1;
    checks++;
    if ({tcb_vld, tcb_wen, tcb_adr} !== {1'b1, 1'b0, 32'h24} || trn_q.size() != 1) begin
      errors++; $display("FAIL ws_next_req: got %h n=%0d expected %h n=1",
                         {tcb_vld, tcb_wen, tcb_adr}, trn_q.size(), {1'b1, 1'b0, 32'h24});
    end
    repeat (5) step();
    checks++;
    if (rsp_q.size() != 2) begin
      errors++; $display("FAIL ws_rsp_count: got %0d expected 2", rsp_q.size());
    end else begin
      checks++;
      if (rsp_q[0] !== {1'b1, 32'h0, 1'b0} || rsp_q[1] !== {1'b0, 32'hC0DE_0024, 1'b0}) begin
        errors++; $display("FAIL ws_rsp_order: got %h %h expected %h %h", rsp_q[0], rsp_q[1],
                           {1'b1, 32'h0, 1'b0}, {1'b0, 32'hC0DE_0024, 1'b0});
      end
    end
    $display("test_wait_states done");
  endtask

  task automatic test_back_pressure();
    int n_acc;
    rsp_q.delete(); trn_q.delete();
    tcb_rdy = 1'b1; rsp_rdy = 1'b0; n_acc = 0;
    cmd_wen = 1'b0; cmd_ben = 4'hF; cmd_wdt = '0;
    for (int k = 0; k < 10; k++) begin
      cmd_vld = (n_acc < 6);
      cmd_adr = 32'h40 + 32'(4 * n_acc);
      #1;
      if (cmd_vld && cmd_rdy) n_acc++;
      step();
    end
    cmd_vld = 1'b1; cmd_adr = 32'h40 + 32'(4 * n_acc);
    #1;
    checks++;
    if (n_acc != 4) begin
      errors++; $display("FAIL bp_accepted: got %0d expected 4", n_acc);
    end
    checks++;
    if ({cmd_rdy, rsp_vld} !== 2'b01) begin
      errors++; $display("FAIL bp_stall: got rdy,vld=%b expected 01", {cmd_rdy, rsp_vld});
    end
    for (int p = 0; p < 2; p++) begin
      rsp_rdy = 1'b1;
      #1;
      checks++;
      if (cmd_rdy !== 1'b1) begin
        errors++; $display("FAIL bp_pop_admits[%0d]: got %b expected 1", p, cmd_rdy);
      end
      if (cmd_rdy) n_acc++;
      step();
      rsp_rdy = 1'b0;
      cmd_adr = 32'h40 + 32'(4 * n_acc);
      cmd_vld = (n_acc < 6);
      #1;
      checks++;
      if (cmd_rdy !== 1'b0) begin
        errors++; $display("FAIL bp_restall[%0d]: got %b expected 0", p, cmd_rdy);
      end
    end
    cmd_vld = 1'b0; rsp_rdy = 1'b1;
    repeat (10) step();
    checks++;
    if (rsp_q.size() != 6) begin
      errors++; $display("FAIL bp_rsp_count: got %0d expected 6", rsp_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (rsp_q[i] !== {1'b0, 16'hC0DE, 16'(16'h40 + 4 * i), 1'b0}) begin
          errors++; $display("FAIL bp_rsp[%0d]: got %h expected %h", i, rsp_q[i],
                             {1'b0, 16'hC0DE, 16'(16'h40 + 4 * i), 1'b0});
        end
      end
    end
    $display("test_back_pressure done");
  endtask

  task automatic test_reset_mid_burst();
    int n_acc;
    rsp_q.delete(); trn_q.delete();
    tcb_rdy = 1'b1; rsp_rdy = 1'b0;
    cmd_wen = 1'b0; cmd_ben = 4'hF; cmd_wdt = '0;
    for (int k = 0; k < 3; k++) begin
      cmd_vld = 1'b1; cmd_adr = 32'h80 + 32'(4 * k);
      #1;
      step();
    end
    cmd_vld = 1'b0;
    #1;
    checks++;
    if ({tcb_vld, rsp_vld} !== 2'b11) begin
      errors++; $display("FAIL rst_pre: got %b expected 11", {tcb_vld, rsp_vld});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tcb_vld, rsp_vld, cmd_rdy} !== 3'b000) begin
      errors++; $display("FAIL rst_async: got %b expected 000", {tcb_vld, rsp_vld, cmd_rdy});
    end
    step(); step();
    rst_n = 1'b1;
    rsp_q.delete(); trn_q.delete();
    n_acc = 0;
    for (int k = 0; k < 8; k++) begin
      cmd_vld = 1'b1; cmd_adr = 32'hC0 + 32'(4 * n_acc);
      #1;
      if (cmd_rdy) n_acc++;
      step();
    end
    checks++;
    if (n_acc != 4) begin
      errors++; $display("FAIL rst_credits: got %0d accepted expected 4", n_acc);
    end
    cmd_vld = 1'b0; rsp_rdy = 1'b1;
    repeat (8) step();
    checks++;
    if (rsp_q.size() != 4) begin
      errors++; $display("FAIL rst_rsp_count: got %0d expected 4", rsp_q.size());
    end else begin
      checks++;
      if (rsp_q[0] !== {1'b0, 32'hC0DE_00C0, 1'b0}) begin
        errors++; $display("FAIL rst_no_stale: got %h expected %h", rsp_q[0], {1'b0, 32'hC0DE_00C0, 1'b0});
      end
    end
    $display("test_reset_mid_burst done");
  endtask

  task automatic test_streaming();
    int n;
    int stall;
    logic w;
    rsp_q.delete(); trn_q.delete();
    err_adr = 32'h110;
    tcb_rdy = 1'b1; rsp_rdy = 1'b1; n = 0; stall = 0;
    for (int k = 0; k < 40 && n < 16; k++) begin
      cmd_vld = 1'b1; cmd_wen = (n % 2 == 1); cmd_adr = 32'h100 + 32'(4 * n);
      cmd_ben = 4'hF; cmd_wdt = 32'(n);
      #1;
      if (cmd_rdy) n++; else stall++;
      step();
    end
    cmd_vld = 1'b0;
    repeat (6) step();
    checks++;
    if (n != 16 || stall != 0) begin
      errors++; $display("FAIL stream_accept: got n=%0d stalls=%0d expected n=16 stalls=0", n, stall);
    end
    checks++;
    if (trn_q.size() != 16) begin
      errors++; $display("FAIL stream_trn_count: got %0d expected 16", trn_q.size());
    end else begin
      checks++;
      if (trn_q[15] - trn_q[0] != 15) begin
        errors++; $display("FAIL stream_consecutive: got span %0d expected 15", trn_q[15] - trn_q[0]);
      end
    end
    checks++;
    if (rsp_q.size() != 16) begin
      errors++; $display("FAIL stream_rsp_count: got %0d expected 16", rsp_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        w = (i % 2 == 1);
        checks++;
        if (rsp_q[i] !== {w, (w ? 32'h0 : rd_val(32'h100 + 32'(4 * i))), (i == 4)}) begin
          errors++; $display("FAIL stream_rsp[%0d]: got %h expected %h", i, rsp_q[i],
                             {w, (w ? 32'h0 : rd_val(32'h100 + 32'(4 * i))), (i == 4)});
        end
      end
    end
    err_adr = 32'hFFFF_FFFF;
    $display("test_streaming done");
  endtask

  initial begin
    test_reset();
    test_single(1'b1, 32'h0, 32'hA5, 32'h0);
    test_single(1'b0, 32'h8, 32'h0, 32'h1234_5678);
    test_wait_states();
    test_back_pressure();
    test_reset_mid_burst();
    test_streaming();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
